gpio_func_switch: RTL and testbench

Per-pin function-select controller that drives the `select` vector of the GPIO alternate-function mux (GPIO vs. peripheral signal per pin) inside `wb_gpio`. It accepts a new target select vector over a valid/ready handshake and performs a break-before-make handover. Every pin whose function changes has its output enable masked for `DEAD_CYCLES` before and after the select flip. Pins whose function does not change are never disturbed.

---
 rtl/gpio_func_switch.sv | 90 +++++++++
 tb/tb_gpio_func_switch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_func_switch.sv
// Break-before-make function-select controller for the GPIO alternate-function mux.
// Pins whose function changes have their output enable masked around the select flip.
module gpio_func_switch #(
   parameter int GPIO_WIDTH  = 16,
   parameter int DEAD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   input  logic [GPIO_WIDTH-1:0] cfg_sel,
   output logic                  cfg_ready,
   output logic [GPIO_WIDTH-1:0] select,
   output logic [GPIO_WIDTH-1:0] oe_mask,
   output logic                  busy,
   output logic                  done
);

   if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead_cycles
      $error("gpio_func_switch: DEAD_CYCLES must be in 1..255");
   end

   localparam logic [7:0] CNT_LOAD = 8'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_t;

   state_t                  state_q;
   logic [7:0]              cnt_q;
   logic [GPIO_WIDTH-1:0]   target_q;
   logic [GPIO_WIDTH-1:0]   select_q;
   logic [GPIO_WIDTH-1:0]   oe_mask_q;
   logic                    done_q;
   logic [GPIO_WIDTH-1:0]   chg_d;

   assign chg_d = cfg_sel ^ select_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         target_q  <= '0;
         select_q  <= '0;
         oe_mask_q <= '1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  target_q <= cfg_sel;
                  if (chg_d == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     oe_mask_q <= ~chg_d;
                     cnt_q     <= CNT_LOAD;
                     state_q   <= (DEAD_CYCLES == 1) ? SWITCH : DRAIN;
                  end
               end
            end
            // SWITCH occupies the last masked cycle before the flip, so DRAIN
            // hands over one count early and the flip lands on edge E(DEAD_CYCLES).
            DRAIN: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= SWITCH;
            end
            SWITCH: begin
               select_q <= target_q;
               cnt_q    <= CNT_LOAD;
               state_q  <= SETTLE;
            end
            SETTLE: begin
               if (cnt_q == 8'd0) begin
                  state_q   <= IDLE;
                  oe_mask_q <= '1;
                  done_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign select    = select_q;
   assign oe_mask   = oe_mask_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign cfg_ready = (state_q == IDLE);

endmodule

// File: tb/tb_gpio_func_switch.sv
// Bench for gpio_func_switch: directed vector table, randomized run against a
// timeline model, and a DEAD_CYCLES=1 back-to-back sequence.
module tb_gpio_func_switch;

   localparam int W  = 16;
   localparam int D4 = 4;

   logic clk;
   logic rst, cfg_valid;
   logic [W-1:0] cfg_sel;
   logic cfg_ready, busy, done;
   logic [W-1:0] select, oe_mask;

   logic rst1, v1;
   logic [W-1:0] sel1;
   logic ready1, busy1, done1;
   logic [W-1:0] select1, mask1;

   int checks = 0;
   int errors = 0;

   gpio_func_switch #(.GPIO_WIDTH(W), .DEAD_CYCLES(D4)) u_dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
      .cfg_ready(cfg_ready), .select(select), .oe_mask(oe_mask),
      .busy(busy), .done(done));

   gpio_func_switch #(.GPIO_WIDTH(W), .DEAD_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst1), .cfg_valid(v1), .cfg_sel(sel1),
      .cfg_ready(ready1), .select(select1), .oe_mask(mask1),
      .busy(busy1), .done(done1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timeline model: k counts edges since accept; flip at k==D, release at k==2D.
   logic [W-1:0] m_sel = '0, m_mask = '1, m_tgt = '0;
   logic         m_busy = 1'b0, m_done = 1'b0;
   int           m_k = 0;

   task automatic model_step(input logic r, input logic v, input logic [W-1:0] s);
      logic [W-1:0] c;
      if (r) begin
         m_sel = '0; m_mask = '1; m_busy = 1'b0; m_done = 1'b0; m_k = 0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (v) begin
               c = s ^ m_sel;
               if (c == '0) m_done = 1'b1;
               else begin
                  m_busy = 1'b1; m_k = 0; m_tgt = s; m_mask = ~c;
               end
            end
         end else begin
            m_k++;
            if (m_k == D4) m_sel = m_tgt;
            if (m_k == 2 * D4) begin
               m_busy = 1'b0; m_mask = '1; m_done = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   logic [W-1:0] prev_sel, prev_mask;
   logic         prev_rst;

   task automatic tick();
      prev_sel  = select;
      prev_mask = oe_mask;
      prev_rst  = rst;
      model_step(rst, cfg_valid, cfg_sel);
      @(posedge clk);
      #1;
   endtask

   // A changed select bit must be masked on both sides of the flip.
   task automatic bbm_check();
      logic [W-1:0] flip;
      flip = select ^ prev_sel;
      if (!prev_rst && flip != '0) begin
         chk("bbm_mask_before", flip & prev_mask, '0);
         chk("bbm_mask_after", flip & oe_mask, '0);
      end
   endtask

   typedef struct {
      logic         r;
      logic         v;
      logic [W-1:0] s;
      logic [W-1:0] e_sel;
      logic [W-1:0] e_mask;
      logic         e_busy;
      logic         e_done;
   } vec_t;

   vec_t vq[$];

   task automatic addv(input logic r, input logic v, input logic [W-1:0] s,
                       input logic [W-1:0] es, input logic [W-1:0] em,
                       input logic eb, input logic ed);
      vq.push_back('{r, v, s, es, em, eb, ed});
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_sel = '0;
      rst1 = 1'b1; v1 = 1'b0; sel1 = '0;

      // Reset, then a 0x0005 handover from select=0.
      addv(1, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);
      addv(0, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);
      addv(0, 1, 16'h0005, 16'h0000, 16'hFFFA, 1, 0);
      for (int i = 1; i < 4; i++) addv(0, 0, 16'h0000, 16'h0000, 16'hFFFA, 1, 0);
      for (int i = 4; i < 8; i++) addv(0, 0, 16'h0000, 16'h0005, 16'hFFFA, 1, 0);
      addv(0, 0, 16'h0000, 16'h0005, 16'hFFFF, 0, 1);
      addv(0, 0, 16'h0000, 16'h0005, 16'hFFFF, 0, 0);
      // No-change request.
      addv(0, 1, 16'h0005, 16'h0005, 16'hFFFF, 0, 1);
      addv(0, 0, 16'h0005, 16'h0005, 16'hFFFF, 0, 0);
      // 0x0003 request, cfg_sel scribbled to 0xFFFF while busy.
      addv(0, 1, 16'h0003, 16'h0005, 16'hFFF9, 1, 0);
      for (int i = 1; i < 4; i++) addv(0, 1, 16'hFFFF, 16'h0005, 16'hFFF9, 1, 0);
      for (int i = 4; i < 8; i++) addv(0, 0, 16'hFFFF, 16'h0003, 16'hFFF9, 1, 0);
      addv(0, 0, 16'hFFFF, 16'h0003, 16'hFFFF, 0, 1);
      addv(0, 0, 16'h0000, 16'h0003, 16'hFFFF, 0, 0);
      // Reset two cycles into a 0x00F0 handover.
      addv(0, 1, 16'h00F0, 16'h0003, 16'hFF0C, 1, 0);
      addv(0, 0, 16'h0000, 16'h0003, 16'hFF0C, 1, 0);
      addv(0, 0, 16'h0000, 16'h0003, 16'hFF0C, 1, 0);
      addv(1, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);
      for (int i = 0; i < 10; i++) addv(0, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);

      foreach (vq[i]) begin
         rst = vq[i].r; cfg_valid = vq[i].v; cfg_sel = vq[i].s;
         tick();
         chk($sformatf("vec%0d_select", i), select, vq[i].e_sel);
         chk($sformatf("vec%0d_oe_mask", i), oe_mask, vq[i].e_mask);
         chk($sformatf("vec%0d_busy", i), 16'(busy), 16'(vq[i].e_busy));
         chk($sformatf("vec%0d_ready", i), 16'(cfg_ready), 16'(!vq[i].e_busy));
         chk($sformatf("vec%0d_done", i), 16'(done), 16'(vq[i].e_done));
         bbm_check();
      end

      // Randomized run against the timeline model.
      rst = 1'b1; cfg_valid = 1'b0;
      tick();
      for (int i = 0; i < 800; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         cfg_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: cfg_sel = m_sel;
            1: cfg_sel = m_sel ^ (16'h1 << $urandom_range(0, W - 1));
            default: cfg_sel = 16'($urandom);
         endcase
         tick();
         chk("rnd_select", select, m_sel);
         chk("rnd_oe_mask", oe_mask, m_mask);
         chk("rnd_busy", 16'(busy), 16'(m_busy));
         chk("rnd_ready", 16'(cfg_ready), 16'(!m_busy));
         chk("rnd_done", 16'(done), 16'(m_done));
         bbm_check();
      end

      // DEAD_CYCLES=1: back-to-back 0x0001 then 0x0000 with valid held.
      rst = 1'b1; cfg_valid = 1'b0; cfg_sel = '0;
      rst1 = 1'b1; v1 = 1'b0; sel1 = '0;
      tick();
      rst = 1'b0; rst1 = 1'b0;
      v1 = 1'b1; sel1 = 16'h0001;
      tick();
      chk("d1_e0_busy", 16'(busy1), 16'h1);
      chk("d1_e0_mask", mask1, 16'hFFFE);
      chk("d1_e0_select", select1, 16'h0000);
      sel1 = 16'h0000;
      tick();
      chk("d1_e1_select", select1, 16'h0001);
      chk("d1_e1_done", 16'(done1), 16'h0);
      tick();
      chk("d1_e2_done", 16'(done1), 16'h1);
      chk("d1_e2_ready", 16'(ready1), 16'h1);
      chk("d1_e2_mask", mask1, 16'hFFFF);
      tick();
      chk("d1_e3_busy", 16'(busy1), 16'h1);
      chk("d1_e3_mask", mask1, 16'hFFFE);
      chk("d1_e3_done", 16'(done1), 16'h0);
      v1 = 1'b0;
      tick();
      chk("d1_e4_select", select1, 16'h0000);
      chk("d1_e4_busy", 16'(busy1), 16'h1);
      tick();
      chk("d1_e5_done", 16'(done1), 16'h1);
      chk("d1_e5_mask", mask1, 16'hFFFF);
      chk("d1_e5_select", select1, 16'h0000);
      tick();
      chk("d1_e6_done", 16'(done1), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
